conv_operand_buf: RTL
=====================

CONV_OPERAND_BUF -- requirements
Module: conv_operand_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8: operand width in bits.
REQ-002 SHALL have parameter IMG_N, default 4: image is IMG_N x IMG_N.
REQ-003 SHALL have parameter KER_K, default 3: kernel is KER_K x KER_K; OUT_M = IMG_N-KER_K+1 (derived).
REQ-004 SHALL have parameter ACC_W, default 20: signed result width.
REQ-005 SHALL have parameter ADDR_W, default 5: write/read address width; must cover IMG_N²+KER_K².
REQ-006 Ports, in order:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  operand write strobe.
- wr_addr  in  ADDR_W  0..IMG_N²-1 image row-major; IMG_N²..IMG_N²+KER_K²-1 kernel row-major.
- wr_data  in  DATA_W  write data.
- wr_err  out  1  one-cycle pulse: rejected write.
- start  in  1  begin streaming pass.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse: pass complete.
- op_valid  out  1  operand pair valid.
- op_ready  in  1  consumer accepts pair.
- op_img  out  DATA_W  image operand.
- op_ker  out  DATA_W  kernel operand.
- op_last  out  1  last pair of current window.
- res_valid  in  1  result strobe from array.
- res_data  in  ACC_W  result value.
- rd_addr  in  ADDR_W  result index 0..OUT_M²-1.
- rd_data  out  ACC_W  result readback, combinational.

Function
REQ-007 States: IDLE, STREAM, DRAIN, DONE; busy=1 in STREAM, DRAIN, DONE.
REQ-008 wr_en in IDLE with in-range wr_addr SHALL write wr_data at next edge; out-of-range address, or any write while busy, SHALL leave memory unchanged and pulse wr_err the next cycle.
REQ-009 IDLE + start -> STREAM; window/kernel/result counters cleared; op_valid=1 the following cycle with pair 0. start while busy SHALL be ignored.
REQ-010 Pair order: window (r,c) row-major, then kernel tap (i,j) row-major; op_img=img[(r+i)*IMG_N+c+j], op_ker=ker[i*KER_K+j]; op_last=1 when i=j=KER_K-1.
REQ-011 Pair advances only on op_valid&&op_ready; while op_ready=0, op_valid, op_img, op_ker, op_last SHALL hold stable.
REQ-012 Accepting the final pair (OUT_M²·KER_K²-th) SHALL drop op_valid next cycle and enter DRAIN.
REQ-013 res_valid in STREAM or DRAIN SHALL store res_data at result index res_cnt, res_cnt++; res_valid in IDLE or DONE, or after OUT_M² results, SHALL be ignored.
REQ-014 DRAIN -> DONE when res_cnt=OUT_M² (including result arriving same cycle as final pair); DONE lasts one cycle with done=1, then IDLE.
REQ-015 rd_data SHALL return result[rd_addr] in any state; rd_addr >= OUT_M² returns 0.
REQ-016 Counter wrap: tap j wraps to 0 at KER_K, increments i; window c wraps at OUT_M, increments r; no counter exceeds its range.

Reset
REQ-017 rst_n low SHALL immediately force IDLE, zero all image, kernel and result storage, and drive busy, done, wr_err, op_valid, op_last=0, op_img=op_ker=0.
REQ-018 Reset mid-STREAM SHALL abandon the pass; after release, block is in IDLE and a new start begins from pair 0.

Configuration
REQ-019 Macro CONV_OPERAND_BUF_RELU_EN defined: negative res_data stored as 0; undefined: res_data stored unmodified (two's complement).

Verification
REQ-020 IMG_N=4, KER_K=3; image 1..16, kernel all 1; start; consumer returns window sums -> 36 pairs, op_last on pairs 9,18,27,36; rd_data[0..3]=54,63,90,99; one done pulse.
REQ-021 Same load, op_ready low 5 cycles at pair 4 -> op_img=6, op_ker=1 held stable throughout; sequence resumes unchanged.
REQ-022 wr_en at addr 3 while busy, and at addr 30 in IDLE -> wr_err pulses both times; readback/stream shows image[3]=4.
REQ-023 rst_n low at pair 20 -> op_valid=0, busy=0 immediately; after release, start yields first pair img=0, ker=0 (storage cleared).
REQ-024 res_data=-5 at index 0 -> rd_data[0]=0 with CONV_OPERAND_BUF_RELU_EN, 0xFFFFB (ACC_W=20) without.

Source files
------------

// File: rtl/conv_operand_buf.sv
// conv_operand_buf: holds an IMG_N x IMG_N image and a KER_K x KER_K kernel,
// streams (image, kernel) operand pairs window by window to a MAC array and
// collects one result per window for readback.
// Optional feature macro: CONV_OPERAND_BUF_RELU_EN (clamp negative results to 0).
module conv_operand_buf #(
    parameter int DATA_W = 8,
    parameter int IMG_N  = 4,
    parameter int KER_K  = 3,
    parameter int ACC_W  = 20,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_img,
    output logic [DATA_W-1:0] op_ker,
    output logic              op_last,
    input  logic              res_valid,
    input  logic [ACC_W-1:0]  res_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ACC_W-1:0]  rd_data
);
    localparam int OUT_M  = IMG_N - KER_K + 1;
    localparam int IMG_SZ = IMG_N * IMG_N;
    localparam int KER_SZ = KER_K * KER_K;
    localparam int RES_SZ = OUT_M * OUT_M;
    localparam int IMG_AW = (IMG_SZ > 1) ? $clog2(IMG_SZ) : 1;
    localparam int KER_AW = (KER_SZ > 1) ? $clog2(KER_SZ) : 1;
    localparam int RES_AW = (RES_SZ > 1) ? $clog2(RES_SZ) : 1;
    localparam int CNT_W  = $clog2(IMG_N + 1);
    localparam int RCNT_W = $clog2(RES_SZ + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TAP_MAX   = CNT_W'(KER_K - 1);
    localparam logic [CNT_W-1:0]  WIN_MAX   = CNT_W'(OUT_M - 1);
    localparam logic [ADDR_W-1:0] IMG_SZ_A  = ADDR_W'(IMG_SZ);
    localparam logic [ADDR_W-1:0] TOT_SZ_A  = ADDR_W'(IMG_SZ + KER_SZ);
    localparam logic [ADDR_W-1:0] RES_SZ_A  = ADDR_W'(RES_SZ);
    localparam logic [RCNT_W-1:0] RES_SZ_C  = RCNT_W'(RES_SZ);
    localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_r, state_s;

    logic [DATA_W-1:0] img_mem_r [IMG_SZ];
    logic [DATA_W-1:0] ker_mem_r [KER_SZ];
    logic [ACC_W-1:0]  res_mem_r [RES_SZ];

    logic [CNT_W-1:0]  win_r_r, win_c_r, tap_i_r, tap_j_r;
    logic [CNT_W-1:0]  nxt_r_s, nxt_c_s, nxt_i_s, nxt_j_s;
    logic [RCNT_W-1:0] res_cnt_r;

    logic              op_valid_r, op_last_r, busy_r, done_r, wr_err_r;
    logic [DATA_W-1:0] op_img_r, op_ker_r;

    logic              accept_s, final_s, load_s;
    logic              wr_img_s, wr_ker_s, wr_rej_s, res_we_s;
    logic [IMG_AW-1:0] img_idx_s;
    logic [KER_AW-1:0] ker_idx_s;

    // Value written into result storage (optionally rectified).
    function automatic logic [ACC_W-1:0] store_val_f(input logic [ACC_W-1:0] v);
`ifdef CONV_OPERAND_BUF_RELU_EN
        if (v[ACC_W-1]) begin
            store_val_f = {ACC_W{1'b0}};
        end else begin
            store_val_f = v;
        end
`else
        store_val_f = v;
`endif
    endfunction

    assign accept_s = op_valid_r & op_ready;
    assign final_s  = (win_r_r == WIN_MAX) && (win_c_r == WIN_MAX) &&
                      (tap_i_r == TAP_MAX) && (tap_j_r == TAP_MAX);

    // Write-port decode: writes land only in IDLE and only inside the operand map.
    always_comb begin
        wr_img_s = wr_en && (state_r == IDLE) && (wr_addr < IMG_SZ_A);
        wr_ker_s = wr_en && (state_r == IDLE) && (wr_addr >= IMG_SZ_A) && (wr_addr < TOT_SZ_A);
        wr_rej_s = wr_en && !(wr_img_s || wr_ker_s);
        res_we_s = res_valid && ((state_r == STREAM) || (state_r == DRAIN)) && (res_cnt_r < RES_SZ_C);
    end

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = STREAM;
                else       state_s = IDLE;
            end
            STREAM: begin
                if (accept_s && final_s) state_s = DRAIN;
                else                     state_s = STREAM;
            end
            DRAIN: begin
                if (res_cnt_r == RES_SZ_C) state_s = DONE;
                else                       state_s = DRAIN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next window/tap position: cleared on start, stepped on each accepted pair.
    always_comb begin
        nxt_r_s = win_r_r;
        nxt_c_s = win_c_r;
        nxt_i_s = tap_i_r;
        nxt_j_s = tap_j_r;
        load_s  = 1'b0;
        if ((state_r == IDLE) && start) begin
            nxt_r_s = CNT_ZERO;
            nxt_c_s = CNT_ZERO;
            nxt_i_s = CNT_ZERO;
            nxt_j_s = CNT_ZERO;
            load_s  = 1'b1;
        end else if ((state_r == STREAM) && accept_s && !final_s) begin
            load_s = 1'b1;
            if (tap_j_r == TAP_MAX) begin
                nxt_j_s = CNT_ZERO;
                if (tap_i_r == TAP_MAX) begin
                    nxt_i_s = CNT_ZERO;
                    if (win_c_r == WIN_MAX) begin
                        nxt_c_s = CNT_ZERO;
                        nxt_r_s = win_r_r + CNT_ONE;
                    end else begin
                        nxt_c_s = win_c_r + CNT_ONE;
                    end
                end else begin
                    nxt_i_s = tap_i_r + CNT_ONE;
                end
            end else begin
                nxt_j_s = tap_j_r + CNT_ONE;
            end
        end else begin
            load_s = 1'b0;
        end
        img_idx_s = IMG_AW'((32'(nxt_r_s) + 32'(nxt_i_s)) * IMG_N + 32'(nxt_c_s) + 32'(nxt_j_s));
        ker_idx_s = KER_AW'(32'(nxt_i_s) * KER_K + 32'(nxt_j_s));
    end

    // Sequencer state, position counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            win_r_r    <= CNT_ZERO;
            win_c_r    <= CNT_ZERO;
            tap_i_r    <= CNT_ZERO;
            tap_j_r    <= CNT_ZERO;
            op_valid_r <= 1'b0;
            op_last_r  <= 1'b0;
            op_img_r   <= {DATA_W{1'b0}};
            op_ker_r   <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wr_err_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            win_r_r    <= nxt_r_s;
            win_c_r    <= nxt_c_s;
            tap_i_r    <= nxt_i_s;
            tap_j_r    <= nxt_j_s;
            op_valid_r <= (state_s == STREAM);
            busy_r     <= (state_s != IDLE);
            done_r     <= (state_s == DONE);
            wr_err_r   <= wr_rej_s;
            if (load_s) begin
                op_img_r  <= img_mem_r[img_idx_s];
                op_ker_r  <= ker_mem_r[ker_idx_s];
                op_last_r <= (nxt_i_s == TAP_MAX) && (nxt_j_s == TAP_MAX);
            end
        end
    end

    // Image and kernel storage, loaded through the write port while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < IMG_SZ; k++) img_mem_r[k] <= {DATA_W{1'b0}};
            for (int k = 0; k < KER_SZ; k++) ker_mem_r[k] <= {DATA_W{1'b0}};
        end else begin
            if (wr_img_s) img_mem_r[IMG_AW'(wr_addr)] <= wr_data;
            if (wr_ker_s) ker_mem_r[KER_AW'(wr_addr - IMG_SZ_A)] <= wr_data;
        end
    end

    // Result storage: results fill sequentially from index 0 each pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_r <= {RCNT_W{1'b0}};
            for (int k = 0; k < RES_SZ; k++) res_mem_r[k] <= {ACC_W{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            res_cnt_r <= {RCNT_W{1'b0}};
        end else if (res_we_s) begin
            res_mem_r[RES_AW'(res_cnt_r)] <= store_val_f(res_data);
            res_cnt_r                     <= res_cnt_r + RCNT_ONE;
        end
    end

    // Combinational result readback; unused indices read as zero.
    always_comb begin
        rd_data = {ACC_W{1'b0}};
        if (rd_addr < RES_SZ_A) begin
            rd_data = res_mem_r[RES_AW'(rd_addr)];
        end else begin
            rd_data = {ACC_W{1'b0}};
        end
    end

    assign op_valid = op_valid_r;
    assign op_img   = op_img_r;
    assign op_ker   = op_ker_r;
    assign op_last  = op_last_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign wr_err   = wr_err_r;

endmodule
